// File: rtl/mix_columns_engine.sv
// mix_columns_engine: column-serial AES MixColumns / InverseMixColumns
// for NB-column states, COLS_PER_CYCLE columns transformed per clock.
// Ports:
//   clk, rst         rising-edge clock, async active-high reset
//   in_valid/ready   input handshake; state (32*NB bits), inverse (mode)
//   out_valid/ready  output handshake; state_out (32*NB bits)
//   busy             high while a state is being processed or held
module mix_columns_engine #(
  parameter int NB             = 4,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            inverse,
  input  logic [32*NB-1:0] state,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*NB-1:0] state_out,
  output logic            busy
);

  localparam int SW    = 32 * NB;
  localparam int NBEAT = NB / COLS_PER_CYCLE;
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [BW-1:0] LAST = BW'(NBEAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } fsm_t;

  fsm_t            r_fsm;
  logic [SW-1:0]   r_work;
  logic [SW-1:0]   r_state_out;
  logic            r_inv;
  logic [BW-1:0]   r_beat;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  logic [31:0]     w_src [COLS_PER_CYCLE];
  logic [31:0]     w_mix [COLS_PER_CYCLE];
  logic [SW-1:0]   w_next;
  int              w_base;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 in the top byte. Every coefficient is a XOR of the
  // x1/x2/x4/x8 multiples: 3=2^1, 9=8^1, B=8^2^1, D=8^4^1, E=8^4^2.
  function automatic logic [31:0] mix_col(
    input logic [31:0] c,
    input logic        inv
  );
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [7:0]  o;
    logic [31:0] res;
    int          r1, r2, r3;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = c[8*(3-r) +: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    for (int r = 0; r < 4; r++) begin
      r1 = (r + 1) % 4;
      r2 = (r + 2) % 4;
      r3 = (r + 3) % 4;
      if (inv) begin
        o = (x8[r]  ^ x4[r]  ^ x2[r])
          ^ (x8[r1] ^ x2[r1] ^ a[r1])
          ^ (x8[r2] ^ x4[r2] ^ a[r2])
          ^ (x8[r3] ^ a[r3]);
      end else begin
        o = x2[r] ^ x2[r1] ^ a[r1] ^ a[r2] ^ a[r3];
      end
      res[8*(3-r) +: 8] = o;
    end
    return res;
  endfunction

  assign w_base = int'(r_beat) * COLS_PER_CYCLE;

  // Mux the beat's columns out of the work register, transform only
  // COLS_PER_CYCLE of them, then steer the results back by column.
  always_comb begin
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      w_src[j] = '0;
      for (int c = 0; c < NB; c++) begin
        if (c == w_base + j) begin
          w_src[j] = r_work[(NB-1-c)*32 +: 32];
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      w_mix[j] = mix_col(w_src[j], r_inv);
    end
  end

  always_comb begin
    w_next = r_state_out;
    for (int c = 0; c < NB; c++) begin
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
        if (c == w_base + j) begin
          w_next[(NB-1-c)*32 +: 32] = w_mix[j];
        end
      end
    end
  end

  // in_ready has its own register so it reads 0 during reset and
  // only rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_work      <= '0;
      r_state_out <= '0;
      r_inv       <= 1'b0;
      r_beat      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (r_in_ready && in_valid) begin
            r_work     <= state;
            r_inv      <= inverse;
            r_beat     <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_fsm      <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_state_out <= w_next;
          if (r_beat == LAST) begin
            r_out_valid <= 1'b1;
            r_fsm       <= S_DONE;
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_fsm       <= S_IDLE;
          end
        end
        default: begin
          r_fsm <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign state_out = r_state_out;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb_mix_columns_engine: scoreboard bench for three NB/COLS_PER_CYCLE
// configurations, directed AES vectors plus randomized traffic.
module tb_mix_columns_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] VF_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VF_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VI_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] VI_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

  // Generic GF(2^8) multiply mod 0x11B (shift-and-add).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Matrix-times-column over every column of an nb-column state.
  function automatic logic [255:0] ref_mix(
    input logic [255:0] s,
    input int           nb,
    input logic         inv
  );
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [255:0] res;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    res = '0;
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(coef[(k - r + 4) % 4],
                           s[(4*nb-1-(4*c+k))*8 +: 8]);
        end
        res[(4*nb-1-(4*c+r))*8 +: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic check(
    input string        nm,
    input int           g,
    input logic [255:0] act,
    input logic [255:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cfg%0d %s: got %0h want %0h", g, nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input int g);
    n_cmp++;
    n_err++;
    $display("FAIL cfg%0d %s", g, nm);
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int NB    = (g == 1) ? 8 : 4;
    localparam int CPC   = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    localparam int NBEAT = NB / CPC;
    localparam int SW    = 32 * NB;
    localparam int KR    = (NBEAT > 2) ? 2 : NBEAT - 1;

    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          inverse;
    logic [SW-1:0] state;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] state_out;
    logic          busy;

    logic [SW-1:0] q_d [$];
    int            q_acc [$];
    int            last_acc;
    bit            rnd_or;
    bit            fin = 1'b0;

    mix_columns_engine #(
      .NB(NB),
      .COLS_PER_CYCLE(CPC)
    ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .inverse(inverse),
      .state(state),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .state_out(state_out),
      .busy(busy)
    );

    function automatic logic [SW-1:0] rep(input logic [127:0] v);
      logic [SW-1:0] r;
      for (int i = 0; i < NB / 4; i++) r[i*128 +: 128] = v;
      return r;
    endfunction

    function automatic logic [SW-1:0] rnd();
      logic [SW-1:0] r;
      for (int i = 0; i < NB; i++) r[i*32 +: 32] = $urandom;
      return r;
    endfunction

    function automatic logic [SW-1:0] model(input logic [SW-1:0] v, input logic inv);
      logic [255:0] full;
      full = ref_mix(256'(v), NB, inv);
      return full[SW-1:0];
    endfunction

    // Monitor: latency on rise, hold while stalled, compare on handoff.
    initial begin
      logic          prev_ov;
      logic          chk_ir;
      logic [SW-1:0] held;
      prev_ov = 1'b0;
      chk_ir  = 1'b0;
      held    = '0;
      forever begin
        @(negedge clk);
        #1;
        if (rst) begin
          prev_ov = 1'b0;
          chk_ir  = 1'b0;
        end else begin
          if (chk_ir) begin
            check("in_ready/out_valid after handoff", g,
                  256'({in_ready, out_valid}), 256'(2'b10));
            chk_ir = 1'b0;
          end
          if (out_valid && !prev_ov) begin
            held = state_out;
            if (q_acc.size() == 0) fail_now("unexpected out_valid", g);
            else check("latency", g, 256'(cyc - q_acc[0]), 256'(NBEAT));
          end else if (out_valid) begin
            check("held state_out", g, 256'(state_out), 256'(held));
            check("held in_ready/busy", g,
                  256'({in_ready, busy}), 256'(2'b01));
          end
          if (out_valid && out_ready) begin
            if (q_d.size() == 0) begin
              fail_now("result with empty scoreboard", g);
            end else begin
              check("state_out", g, 256'(state_out), 256'(q_d.pop_front()));
              void'(q_acc.pop_front());
            end
            chk_ir = 1'b1;
          end
          prev_ov = out_valid;
        end
      end
    end

    task automatic send(
      input logic [SW-1:0] d,
      input logic          inv,
      input logic [SW-1:0] exp
    );
      int n;
      state    = d;
      inverse  = inv;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
        @(negedge clk);
        if (rnd_or) out_ready = ($urandom_range(0, 1) == 1);
        n++;
      end
      if (!in_ready) begin
        fail_now("accept timeout", g);
      end else begin
        last_acc = cyc + 1;
        q_d.push_back(exp);
        q_acc.push_back(last_acc);
      end
      @(negedge clk);
      in_valid = 1'b0;
      inverse  = ~inv;
      state    = rnd();
    endtask

    task automatic wait_idle();
      int n;
      n = 0;
      while ((q_d.size() != 0 || !in_ready) && n < 500) begin
        @(negedge clk);
        if (rnd_or) out_ready = ($urandom_range(0, 1) == 1);
        n++;
      end
      if (q_d.size() != 0 || !in_ready) fail_now("drain timeout", g);
    endtask

    task automatic wait_ov();
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) fail_now("out_valid timeout", g);
    endtask

    initial begin
      logic [SW-1:0] v;
      logic [SW-1:0] r;
      logic          m;
      int            a1;
      rst       = 1'b1;
      in_valid  = 1'b0;
      inverse   = 1'b0;
      state     = '0;
      out_ready = 1'b1;
      rnd_or    = 1'b0;
      last_acc  = 0;
      repeat (2) @(negedge clk);
      check("reset ctl", g, 256'({in_ready, out_valid, busy}), 256'(0));
      check("reset state_out", g, 256'(state_out), 256'(0));
      rst = 1'b0;
      @(negedge clk);
      check("in_ready after release", g, 256'(in_ready), 256'(1));

      send(rep(VF_IN), 1'b0, rep(VF_OUT));
      wait_idle();
      send(rep(VI_IN), 1'b1, rep(VI_OUT));
      wait_idle();

      // Back-pressure with a competing request held on the input.
      out_ready = 1'b0;
      send(rep(VF_IN), 1'b0, rep(VF_OUT));
      wait_ov();
      v        = rnd();
      state    = v;
      inverse  = 1'b0;
      in_valid = 1'b1;
      repeat (10) @(negedge clk);
      check("no second accept", g, 256'(q_d.size()), 256'(1));
      out_ready = 1'b1;
      send(v, 1'b0, model(v, 1'b0));
      wait_idle();

      // Back-to-back forward then inverse, out_ready tied high.
      v = rnd();
      r = model(v, 1'b0);
      send(v, 1'b0, r);
      a1 = last_acc;
      send(r, 1'b1, v);
      check("accept gap", g, 256'(last_acc - a1 - 1), 256'(NBEAT + 1));
      wait_idle();

      // Asynchronous reset in the middle of a transaction.
      v = rnd();
      send(v, 1'b0, model(v, 1'b0));
      repeat (KR) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid-reset state_out", g, 256'(state_out), 256'(0));
      check("mid-reset ctl", g,
            256'({out_valid, busy, in_ready}), 256'(0));
      void'(q_d.pop_back());
      void'(q_acc.pop_back());
      @(negedge clk);
      rst = 1'b0;
      v = rnd();
      send(v, 1'b1, model(v, 1'b1));
      wait_idle();

      rnd_or = 1'b1;
      for (int i = 0; i < 30; i++) begin
        v = rnd();
        m = ($urandom_range(0, 1) == 1);
        send(v, m, model(v, m));
      end
      rnd_or = 1'b0;
      out_ready = 1'b1;
      wait_idle();
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && t < 40000) begin
      @(posedge clk);
      t++;
    end
    if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin)) begin
      n_cmp++;
      n_err++;
      $display("FAIL global timeout: configurations unfinished");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
